// File: rtl/kbest_layer_sched.sv
// K-best layer-5/6 scheduler: walks parents 0..7 through the shared
// expansion unit, keeps a per-parent prefix of each sorted child stream
// in a 40-entry candidate buffer, then kicks the global sort.
// Optional watchdog: define SCHED_TIMEOUT_EN to enable the 8-bit stall timeout (err).
`timescale 1ns/1ps
module kbest_layer_sched (
    input  logic       clk,
    input  logic       rstn,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       exp_req,
    output logic [2:0] exp_idx,
    input  logic       exp_ack,
    input  logic       res_valid,
    output logic       wr_en,
    output logic [5:0] wr_addr,
    output logic       sort_start,
    input  logic       sort_done,
    output logic       err
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ     = 3'd1,
        S_COLLECT = 3'd2,
        S_SORT    = 3'd3,
        S_FIN     = 3'd4
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [2:0] r_n;
    logic [3:0] r_beat;
    logic       r_sort_start;
    logic [3:0] w_keep;
    logic [5:0] w_base;
    logic       w_last_beat;

    // Keep count and buffer base for the current parent
    always_comb begin
        w_keep = 4'd2;
        case (r_n[2:1])
            2'd0:    w_keep = 4'd8;
            2'd1:    w_keep = 4'd6;
            2'd2:    w_keep = 4'd4;
            default: w_keep = 4'd2;
        endcase
        w_base = 6'd0;
        case (r_n)
            3'd0:    w_base = 6'd0;
            3'd1:    w_base = 6'd8;
            3'd2:    w_base = 6'd16;
            3'd3:    w_base = 6'd22;
            3'd4:    w_base = 6'd28;
            3'd5:    w_base = 6'd32;
            3'd6:    w_base = 6'd36;
            default: w_base = 6'd38;
        endcase
    end

    assign w_last_beat = (r_state == S_COLLECT) && res_valid && (r_beat == 4'd15);

`ifdef SCHED_TIMEOUT_EN
    logic [7:0] r_wdog;
    logic       r_err;
    logic       w_wd_clr;
    logic       w_timeout;

    assign w_wd_clr  = ((r_state == S_REQ)     && exp_ack)   ||
                       ((r_state == S_COLLECT) && res_valid) ||
                       ((r_state == S_SORT)    && sort_done);
    // Progress in the same cycle as the 255th count wins over the timeout
    assign w_timeout = ((r_state == S_REQ) || (r_state == S_COLLECT) || (r_state == S_SORT)) &&
                       (r_wdog == 8'hFF) && !w_wd_clr;
    assign err       = r_err;
`else
    assign err = 1'b0;
`endif

    // Next-state and Moore/Mealy outputs
    always_comb begin
        w_next  = r_state;
        busy    = (r_state != S_IDLE);
        done    = (r_state == S_FIN);
        exp_req = (r_state == S_REQ);
        exp_idx = (r_state == S_REQ) ? r_n : 3'd0;
        wr_en   = 1'b0;
        wr_addr = '0;
        case (r_state)
            S_IDLE:    if (start) w_next = S_REQ;
            S_REQ:     if (exp_ack) w_next = S_COLLECT;
            S_COLLECT: begin
                if (res_valid && (r_beat < w_keep)) begin
                    wr_en   = 1'b1;
                    wr_addr = w_base + {2'b00, r_beat};
                end
                if (w_last_beat) w_next = (r_n == 3'd7) ? S_SORT : S_REQ;
            end
            S_SORT:    if (sort_done) w_next = S_FIN;
            S_FIN:     w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
`ifdef SCHED_TIMEOUT_EN
        if (w_timeout) w_next = S_IDLE;
`endif
    end

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Parent index, beat counter and sort_start entry pulse
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_n          <= '0;
            r_beat       <= '0;
            r_sort_start <= 1'b0;
        end else begin
            r_sort_start <= (w_next == S_SORT) && (r_state != S_SORT);
            if ((r_state == S_IDLE) && start)
                r_n <= '0;
            else if (w_last_beat && (r_n != 3'd7))
                r_n <= r_n + 3'd1;
            if ((r_state == S_REQ) && exp_ack)
                r_beat <= '0;
            else if ((r_state == S_COLLECT) && res_valid)
                r_beat <= r_beat + 4'd1;
        end
    end

    assign sort_start = r_sort_start;

`ifdef SCHED_TIMEOUT_EN
    // Watchdog: counts idle cycles in active states, clears on progress or state change
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wdog <= '0;
            r_err  <= 1'b0;
        end else begin
            r_err <= w_timeout;
            if (w_wd_clr || (w_next != r_state) ||
                !((r_state == S_REQ) || (r_state == S_COLLECT) || (r_state == S_SORT)))
                r_wdog <= '0;
            else
                r_wdog <= r_wdog + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_kbest_layer_sched.sv
// Self-checking bench for kbest_layer_sched: randomized passes checked
// against a keep/base reference computed from the per-parent keep profile.
`timescale 1ns/1ps
module tb_kbest_layer_sched;

    logic       clk = 1'b0;
    logic       rstn, start, exp_ack, res_valid, sort_done;
    logic       busy, done, exp_req, wr_en, sort_start, err;
    logic [2:0] exp_idx;
    logic [5:0] wr_addr;

    int tests = 0;
    int fails = 0;
    int wcount[40];

    kbest_layer_sched dut (
        .clk(clk), .rstn(rstn), .start(start), .busy(busy), .done(done),
        .exp_req(exp_req), .exp_idx(exp_idx), .exp_ack(exp_ack),
        .res_valid(res_valid), .wr_en(wr_en), .wr_addr(wr_addr),
        .sort_start(sort_start), .sort_done(sort_done), .err(err)
    );

    always #5 clk = ~clk;

    // Reference: keep shrinks by 2 every two parents; base is the running sum
    function automatic int keep_of(input int n);
        return 8 - 2 * (n / 2);
    endfunction

    function automatic int base_of(input int n);
        int s = 0;
        for (int k = 0; k < n; k++) s += keep_of(k);
        return s;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},   {7'd0, busy},       8'd0);
        chk({tag, "_done"},   {7'd0, done},       8'd0);
        chk({tag, "_expreq"}, {7'd0, exp_req},    8'd0);
        chk({tag, "_expidx"}, {5'd0, exp_idx},    8'd0);
        chk({tag, "_wren"},   {7'd0, wr_en},      8'd0);
        chk({tag, "_wraddr"}, {2'd0, wr_addr},    8'd0);
        chk({tag, "_sstart"}, {7'd0, sort_start}, 8'd0);
        chk({tag, "_err"},    {7'd0, err},        8'd0);
    endtask

    // gapmode: 0 back-to-back beats, 1 toggling 1/0, 2 random gaps.
    // abort_n >= 0 returns mid-COLLECT of that parent (caller then resets).
    task automatic run_pass(input int gapmode, input int maxwait, input int sortdly, input int abort_n);
        int  b, w;
        bit  v, phase, we;
        for (int i = 0; i < 40; i++) wcount[i] = 0;
        @(negedge clk);
        start = 1'b1;
        #1;
        chk("idle_busy", {7'd0, busy}, 8'd0);
        chk("idle_expreq", {7'd0, exp_req}, 8'd0);
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < 8; n++) begin
            w = (maxwait > 0) ? int'($urandom_range(0, maxwait)) : 0;
            for (int c = 0; c <= w; c++) begin
                exp_ack   = (c == w);
                res_valid = (c != w) && ($urandom_range(0, 1) == 1);
                start     = (c != w) && ($urandom_range(0, 1) == 1);
                #1;
                chk("req_expreq", {7'd0, exp_req}, 8'd1);
                chk("req_expidx", {5'd0, exp_idx}, 8'(n));
                chk("req_busy", {7'd0, busy}, 8'd1);
                chk("req_wren", {7'd0, wr_en}, 8'd0);
                @(negedge clk);
            end
            exp_ack = 1'b0;
            start   = 1'b0;
            b       = 0;
            phase   = 1'b1;
            while (b < 16) begin
                case (gapmode)
                    0:       v = 1'b1;
                    1:       begin v = phase; phase = ~phase; end
                    default: v = ($urandom_range(0, 2) != 0);
                endcase
                res_valid = v;
                exp_ack   = ($urandom_range(0, 1) == 1);
                #1;
                chk("col_expreq", {7'd0, exp_req}, 8'd0);
                if (v) begin
                    we = (b < keep_of(n));
                    chk("col_wren", {7'd0, wr_en}, {7'd0, we});
                    chk("col_wraddr", {2'd0, wr_addr}, we ? 8'(base_of(n) + b) : 8'd0);
                    if (wr_en === 1'b1 && wr_addr < 6'd40) wcount[wr_addr]++;
                    b++;
                end else begin
                    chk("gap_wren", {7'd0, wr_en}, 8'd0);
                    chk("gap_wraddr", {2'd0, wr_addr}, 8'd0);
                end
                if (n == abort_n && b == 3) return;
                @(negedge clk);
            end
            res_valid = 1'b0;
            exp_ack   = 1'b0;
        end
        for (int c = 0; c <= sortdly; c++) begin
            sort_done = (c == sortdly);
            res_valid = ($urandom_range(0, 1) == 1);
            #1;
            chk("sort_sstart", {7'd0, sort_start}, (c == 0) ? 8'd1 : 8'd0);
            chk("sort_done", {7'd0, done}, 8'd0);
            chk("sort_busy", {7'd0, busy}, 8'd1);
            chk("sort_wren", {7'd0, wr_en}, 8'd0);
            @(negedge clk);
        end
        sort_done = 1'b0;
        res_valid = 1'b0;
        #1;
        chk("fin_done", {7'd0, done}, 8'd1);
        chk("fin_busy", {7'd0, busy}, 8'd1);
        chk("fin_sstart", {7'd0, sort_start}, 8'd0);
        @(negedge clk);
        #1;
        chk("post_done", {7'd0, done}, 8'd0);
        chk("post_busy", {7'd0, busy}, 8'd0);
        for (int i = 0; i < 40; i++) chk("write_once", 8'(wcount[i]), 8'd1);
    endtask

    initial begin
        rstn = 1'b0; start = 1'b0; exp_ack = 1'b0; res_valid = 1'b0; sort_done = 1'b0;
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;

        run_pass(0, 0, 3, -1);
        run_pass(1, 2, 1, -1);
        run_pass(2, 3, 0, -1);
        for (int r = 0; r < 3; r++)
            run_pass(int'($urandom_range(0, 2)), int'($urandom_range(0, 4)), int'($urandom_range(0, 5)), -1);

        // Reset in mid-pass at parent 3 with inputs still active
        run_pass(2, 2, 0, 3);
        res_valid = 1'b1;
        exp_ack   = 1'b1;
        rstn      = 1'b0;
        #1;
        chk_all_zero("midrst");
        @(negedge clk);
        rstn = 1'b1;
        for (int c = 0; c < 20; c++) begin
            res_valid = ($urandom_range(0, 1) == 1);
            exp_ack   = ($urandom_range(0, 1) == 1);
            sort_done = ($urandom_range(0, 1) == 1);
            #1;
            chk("after_busy", {7'd0, busy}, 8'd0);
            chk("after_done", {7'd0, done}, 8'd0);
            chk("after_sstart", {7'd0, sort_start}, 8'd0);
            chk("after_wren", {7'd0, wr_en}, 8'd0);
            chk("after_err", {7'd0, err}, 8'd0);
            @(negedge clk);
        end
        res_valid = 1'b0; exp_ack = 1'b0; sort_done = 1'b0;

        run_pass(0, 1, 2, -1);

`ifdef SCHED_TIMEOUT_EN
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 256; k++) begin
            #1;
            chk("wd_err_low", {7'd0, err}, 8'd0);
            chk("wd_busy", {7'd0, busy}, 8'd1);
            @(negedge clk);
        end
        #1;
        chk("wd_err", {7'd0, err}, 8'd1);
        chk("wd_idle", {7'd0, busy}, 8'd0);
        chk("wd_nodone", {7'd0, done}, 8'd0);
        @(negedge clk);
        #1;
        chk("wd_err_pulse", {7'd0, err}, 8'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
